writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final (WB) stage of the RV32 pipeline with single-precision FP support.
- Selects the result to retire from three sources: ALU, load data, and FPU.
- Drives the integer and FP register-file write ports.
- Holds a one-cycle-old copy of the retired write for WB-to-ID bypass, plus per-source retire counters.
- Data selection is purely combinational; only the bypass copy and the counters are clocked.

Parameters:
- XLEN, 32, data width of all result paths.
- CNT_W, 32, width of each retire counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_result_wb  in  XLEN  integer ALU result.
- mem_rdata_wb  in  XLEN  load data, already sign/zero-extended by the MEM stage.
- fpu_result_wb  in  XLEN  FPU result, IEEE-754 single-precision bit pattern.
- mem_to_reg_wb  in  1  selects load data.
- fp_op_wb  in  1  selects FPU result; also marks the destination as the FP register file.
- reg_write_wb  in  1  instruction writes a destination register.
- rd_addr_wb  in  5  destination register index.
- wb_data  out  XLEN  selected writeback value.
- int_we  out  1  integer register-file write enable.
- fp_we  out  1  FP register-file write enable.
- wb_rd_addr  out  5  register-file write address.
- fwd_valid  out  1  bypass copy is valid.
- fwd_is_fp  out  1  bypass copy targets the FP register file.
- fwd_rd  out  5  bypass destination register index.
- fwd_data  out  XLEN  bypass data.
- cnt_alu  out  CNT_W  retired ALU writes.
- cnt_mem  out  CNT_W  retired load writes.
- cnt_fpu  out  CNT_W  retired FPU writes.

Behaviour:
- wb_data is combinational, zero latency, and independent of clk/rst. Priority:
  - mem_to_reg_wb=1 -> mem_rdata_wb, regardless of fp_op_wb (load data beats FPU).
  - else fp_op_wb=1 -> fpu_result_wb.
  - else -> alu_result_wb.
- Values pass bit-exact; no extension, rounding or NaN handling in this stage.
- Register-file write outputs are combinational:
  - wb_rd_addr = rd_addr_wb.
  - int_we = reg_write_wb & ~fp_op_wb & (rd_addr_wb != 0); x0 is never written.
  - fp_we = reg_write_wb & fp_op_wb; f0 is writable.
  - A load with fp_op_wb=1 (FLW) writes load data into the FP register file.
- Bypass register (posedge clk):
  - rst=1 -> fwd_valid=0, fwd_is_fp=0, fwd_rd=0, fwd_data=0.
  - else if int_we | fp_we -> fwd_valid=1, fwd_rd=rd_addr_wb, fwd_data=wb_data, fwd_is_fp=fp_we.
  - else -> fwd_valid=0; the other fields hold.
- Retire counters (posedge clk):
  - rst=1 -> all counters clear to 0.
  - else if reg_write_wb=1, increment exactly one counter, matching the wb_data priority: cnt_mem if mem_to_reg_wb, else cnt_fpu if fp_op_wb, else cnt_alu.
  - An integer write to x0 still counts as retired.
  - Counters wrap modulo 2^CNT_W with no saturation.
- Reset takes precedence over a simultaneous write.
- Reset never affects wb_data, int_we, fp_we or wb_rd_addr.

Test Plan:
- Default ALU path: alu=0x12345678, mem=0x99999999, fpu=0x88888888, mem_to_reg=0, fp_op=0 -> wb_data=0x12345678 with no clock edge. Repeat with alu=0xFFFFFFFF and alu=0x0 -> wb_data follows alu exactly.
- FPU path: alu=0x11111111, mem=0x22222222, fpu=0x3F800000, fp_op=1 -> wb_data=0x3F800000. Also check fpu=0x7F800000 (+Inf) and fpu=0x00000000 (+0.0) pass through unchanged.
- Priority mem over fpu: alu=0x11111111, mem=0x22222222, fpu=0x33333333, mem_to_reg=1, fp_op=1 -> wb_data=0x22222222. Same setup with mem=0xFFFFFFF0 -> 0xFFFFFFF0.
- Sequential switching, i=0..3: alu=0x10000000+i, mem=0x20000000+i, fpu=0x30000000+i; cycle the selects ALU -> MEM -> FPU at 10 ns each -> wb_data tracks 0x1000000i, 0x2000000i, 0x3000000i.
- Write enables:
  - reg_write=1, rd=0, fp_op=0 -> int_we=0, fp_we=0.
  - rd=5, fp_op=1 -> fp_we=1, int_we=0.
  - After that edge: fwd_valid=1, fwd_rd=5, fwd_is_fp=1, fwd_data=wb_data.
- Counters and reset: 3 ALU, 2 load, 1 FPU retires -> cnt_alu=3, cnt_mem=2, cnt_fpu=1. Assert rst together with reg_write=1 -> all counters 0 and fwd_valid=0 after the edge, with wb_data still tracking its inputs.

Source files
------------

// File: rtl/writeback_stage.sv
// WB stage: selects ALU/load/FPU result, drives int/FP regfile write ports, keeps a bypass copy and retire counters.
// Latency: data and write enables are combinational; bypass copy and counters update on the next rising edge. No backpressure.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  alu_result_wb,
  input  logic [XLEN-1:0]  mem_rdata_wb,
  input  logic [XLEN-1:0]  fpu_result_wb,
  input  logic             mem_to_reg_wb,
  input  logic             fp_op_wb,
  input  logic             reg_write_wb,
  input  logic [4:0]       rd_addr_wb,
  output logic [XLEN-1:0]  wb_data,
  output logic             int_we,
  output logic             fp_we,
  output logic [4:0]       wb_rd_addr,
  output logic             fwd_valid,
  output logic             fwd_is_fp,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_fpu
);

  // Load data wins over FPU so that FLW retires the loaded word into the FP file.
  always_comb begin
    wb_data = alu_result_wb;
    if (mem_to_reg_wb) begin
      wb_data = mem_rdata_wb;
    end else if (fp_op_wb) begin
      wb_data = fpu_result_wb;
    end
  end

  assign wb_rd_addr = rd_addr_wb;
  assign int_we     = reg_write_wb & ~fp_op_wb & (rd_addr_wb != 5'd0);
  assign fp_we      = reg_write_wb & fp_op_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_is_fp <= 1'b0;
      fwd_rd    <= 5'd0;
      fwd_data  <= '0;
    end else if (int_we | fp_we) begin
      fwd_valid <= 1'b1;
      fwd_is_fp <= fp_we;
      fwd_rd    <= rd_addr_wb;
      fwd_data  <= wb_data;
    end else begin
      fwd_valid <= 1'b0;
    end
  end

  // Writes to x0 still count as retired, so counting keys off reg_write_wb alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_alu <= '0;
      cnt_mem <= '0;
      cnt_fpu <= '0;
    end else if (reg_write_wb) begin
      if (mem_to_reg_wb) begin
        cnt_mem <= cnt_mem + CNT_W'(1);
      end else if (fp_op_wb) begin
        cnt_fpu <= cnt_fpu + CNT_W'(1);
      end else begin
        cnt_alu <= cnt_alu + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: result select, write enables, bypass register and retire counters.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result_wb;
  logic [31:0] mem_rdata_wb;
  logic [31:0] fpu_result_wb;
  logic        mem_to_reg_wb;
  logic        fp_op_wb;
  logic        reg_write_wb;
  logic [4:0]  rd_addr_wb;
  logic [31:0] wb_data;
  logic        int_we;
  logic        fp_we;
  logic [4:0]  wb_rd_addr;
  logic        fwd_valid;
  logic        fwd_is_fp;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] cnt_alu;
  logic [31:0] cnt_mem;
  logic [31:0] cnt_fpu;

  int checks;
  int failures;

  writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .alu_result_wb(alu_result_wb),
    .mem_rdata_wb(mem_rdata_wb),
    .fpu_result_wb(fpu_result_wb),
    .mem_to_reg_wb(mem_to_reg_wb),
    .fp_op_wb(fp_op_wb),
    .reg_write_wb(reg_write_wb),
    .rd_addr_wb(rd_addr_wb),
    .wb_data(wb_data),
    .int_we(int_we),
    .fp_we(fp_we),
    .wb_rd_addr(wb_rd_addr),
    .fwd_valid(fwd_valid),
    .fwd_is_fp(fwd_is_fp),
    .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
    .cnt_alu(cnt_alu),
    .cnt_mem(cnt_mem),
    .cnt_fpu(cnt_fpu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] fpu,
                       input logic m2r, input logic fp, input logic rw, input logic [4:0] rd);
    alu_result_wb = alu;
    mem_rdata_wb  = mem;
    fpu_result_wb = fpu;
    mem_to_reg_wb = m2r;
    fp_op_wb      = fp;
    reg_write_wb  = rw;
    rd_addr_wb    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'hCAFE0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    tick();
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    checks++; if (fwd_is_fp !== 1'b0) begin failures++; $display("FAIL reset_fwd_is_fp got=%b exp=0", fwd_is_fp); end
    checks++; if (fwd_rd !== 5'd0) begin failures++; $display("FAIL reset_fwd_rd got=%0d exp=0", fwd_rd); end
    checks++; if (fwd_data !== 32'h0) begin failures++; $display("FAIL reset_fwd_data got=%h exp=0", fwd_data); end
    checks++; if ({cnt_alu, cnt_mem, cnt_fpu} !== 96'h0) begin failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cnt_alu, cnt_mem, cnt_fpu); end
    checks++; if (wb_data !== 32'hCAFE0001) begin failures++; $display("FAIL reset_wb_data got=%h exp=cafe0001", wb_data); end
    checks++; if (int_we !== 1'b1 || wb_rd_addr !== 5'd3) begin failures++; $display("FAIL reset_we_passthru got=%b/%0d exp=1/3", int_we, wb_rd_addr); end
    rst = 1'b0;
    reg_write_wb = 1'b0;
    tick();
  endtask

  task automatic test_alu_path();
    logic [31:0] alus [3];
    alus[0] = 32'h12345678; alus[1] = 32'hFFFFFFFF; alus[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      drive(alus[i], 32'h99999999, 32'h88888888, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (wb_data !== alus[i]) begin failures++; $display("FAIL alu_path[%0d] got=%h exp=%h", i, wb_data, alus[i]); end
    end
  endtask

  task automatic test_fpu_path();
    logic [31:0] fpus [3];
    fpus[0] = 32'h3F800000; fpus[1] = 32'h7F800000; fpus[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      drive(32'h11111111, 32'h22222222, fpus[i], 1'b0, 1'b1, 1'b0, 5'd0);
      #1;
      checks++; if (wb_data !== fpus[i]) begin failures++; $display("FAIL fpu_path[%0d] got=%h exp=%h", i, wb_data, fpus[i]); end
    end
  endtask

  task automatic test_priority();
    drive(32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (wb_data !== 32'h22222222) begin failures++; $display("FAIL prio_mem_over_fpu got=%h exp=22222222", wb_data); end
    mem_rdata_wb = 32'hFFFFFFF0;
    #1;
    checks++; if (wb_data !== 32'hFFFFFFF0) begin failures++; $display("FAIL prio_mem_neg got=%h exp=fffffff0", wb_data); end
    mem_to_reg_wb = 1'b1; fp_op_wb = 1'b0;
    #1;
    checks++; if (wb_data !== 32'hFFFFFFF0) begin failures++; $display("FAIL prio_mem_only got=%h exp=fffffff0", wb_data); end
  endtask

  task automatic test_switching();
    for (int i = 0; i < 4; i++) begin
      drive(32'h10000000 + i, 32'h20000000 + i, 32'h30000000 + i, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (wb_data !== 32'h10000000 + i) begin failures++; $display("FAIL switch_alu[%0d] got=%h exp=%h", i, wb_data, 32'h10000000 + i); end
      #9;
      mem_to_reg_wb = 1'b1;
      #1;
      checks++; if (wb_data !== 32'h20000000 + i) begin failures++; $display("FAIL switch_mem[%0d] got=%h exp=%h", i, wb_data, 32'h20000000 + i); end
      #9;
      mem_to_reg_wb = 1'b0; fp_op_wb = 1'b1;
      #1;
      checks++; if (wb_data !== 32'h30000000 + i) begin failures++; $display("FAIL switch_fpu[%0d] got=%h exp=%h", i, wb_data, 32'h30000000 + i); end
      #9;
    end
  endtask

  task automatic test_write_enables();
    // x0 integer write: suppressed, no bypass
    drive(32'hAAAA0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    checks++; if (int_we !== 1'b0 || fp_we !== 1'b0) begin failures++; $display("FAIL we_x0 got=int%b/fp%b exp=0/0", int_we, fp_we); end
    tick();
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_x0_valid got=%b exp=0", fwd_valid); end
    // FP write to f5
    drive(32'h1, 32'h2, 32'h40490FDB, 1'b0, 1'b1, 1'b1, 5'd5);
    #1;
    checks++; if (fp_we !== 1'b1 || int_we !== 1'b0) begin failures++; $display("FAIL we_fp got=int%b/fp%b exp=0/1", int_we, fp_we); end
    tick();
    checks++; if ({fwd_valid, fwd_is_fp, fwd_rd, fwd_data} !== {1'b1, 1'b1, 5'd5, 32'h40490FDB})
      begin failures++; $display("FAIL fwd_fp got=v%b fp%b rd%0d d%h exp=v1 fp1 rd5 d40490fdb", fwd_valid, fwd_is_fp, fwd_rd, fwd_data); end
    // FLW into f0: load data to FP file
    drive(32'h1, 32'hBF000000, 32'h3, 1'b1, 1'b1, 1'b1, 5'd0);
    #1;
    checks++; if (fp_we !== 1'b1 || int_we !== 1'b0 || wb_data !== 32'hBF000000) begin failures++; $display("FAIL we_flw got=int%b/fp%b d%h exp=0/1 dbf000000", int_we, fp_we, wb_data); end
    // Integer write to x9
    tick();
    drive(32'h00C0FFEE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    checks++; if (int_we !== 1'b1 || fp_we !== 1'b0 || wb_rd_addr !== 5'd9) begin failures++; $display("FAIL we_int got=int%b/fp%b rd%0d exp=1/0/9", int_we, fp_we, wb_rd_addr); end
    tick();
    checks++; if ({fwd_valid, fwd_is_fp, fwd_rd, fwd_data} !== {1'b1, 1'b0, 5'd9, 32'h00C0FFEE})
      begin failures++; $display("FAIL fwd_int got=v%b fp%b rd%0d d%h exp=v1 fp0 rd9 d00c0ffee", fwd_valid, fwd_is_fp, fwd_rd, fwd_data); end
    reg_write_wb = 1'b0;
  endtask

  task automatic test_counters_reset();
    rst = 1'b1; reg_write_wb = 1'b0;
    tick();
    rst = 1'b0;
    // 3 ALU (one to x0), 2 loads, 1 FPU
    drive(32'hA1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1); tick();
    drive(32'hA2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0); tick();
    drive(32'hA3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2); tick();
    drive(32'h0, 32'hB1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3); tick();
    drive(32'h0, 32'hB2, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4); tick();
    drive(32'h0, 32'h0, 32'hC1, 1'b0, 1'b1, 1'b1, 5'd7); tick();
    checks++; if (cnt_alu !== 32'd3) begin failures++; $display("FAIL cnt_alu got=%0d exp=3", cnt_alu); end
    checks++; if (cnt_mem !== 32'd2) begin failures++; $display("FAIL cnt_mem got=%0d exp=2", cnt_mem); end
    checks++; if (cnt_fpu !== 32'd1) begin failures++; $display("FAIL cnt_fpu got=%0d exp=1", cnt_fpu); end
    // idle: valid drops, fields hold, counters hold
    drive(32'hDEAD, 32'hBEEF, 32'hF00D, 1'b0, 1'b0, 1'b0, 5'd12); tick();
    checks++; if ({fwd_valid, fwd_is_fp, fwd_rd, fwd_data} !== {1'b0, 1'b1, 5'd7, 32'hC1})
      begin failures++; $display("FAIL fwd_hold got=v%b fp%b rd%0d d%h exp=v0 fp1 rd7 dc1", fwd_valid, fwd_is_fp, fwd_rd, fwd_data); end
    checks++; if ({cnt_alu, cnt_mem, cnt_fpu} !== {32'd3, 32'd2, 32'd1}) begin failures++; $display("FAIL cnt_idle got=%0d/%0d/%0d exp=3/2/1", cnt_alu, cnt_mem, cnt_fpu); end
    // reset beats a simultaneous write
    rst = 1'b1;
    drive(32'h1, 32'h5A5A5A5A, 32'h2, 1'b1, 1'b0, 1'b1, 5'd8);
    #1;
    checks++; if (wb_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL rst_wb_data got=%h exp=5a5a5a5a", wb_data); end
    tick();
    checks++; if ({cnt_alu, cnt_mem, cnt_fpu} !== 96'h0) begin failures++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", cnt_alu, cnt_mem, cnt_fpu); end
    checks++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin failures++; $display("FAIL rst_fwd got=v%b rd%0d d%h exp=v0 rd0 d0", fwd_valid, fwd_rd, fwd_data); end
    alu_result_wb = 32'h77777777; mem_to_reg_wb = 1'b0;
    #1;
    checks++; if (wb_data !== 32'h77777777 || int_we !== 1'b1) begin failures++; $display("FAIL rst_comb_track got=%h we%b exp=77777777 we1", wb_data, int_we); end
    rst = 1'b0;
    reg_write_wb = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_alu_path();
    test_fpu_path();
    test_priority();
    test_switching();
    test_write_enables();
    test_counters_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
